quad_enc_imit: RTL and testbench

- Single-channel quadrature encoder imitator; the transmit-side counterpart of the encoder receiver channels.
- Converts step/dir count requests into rate-limited A/B quadrature edges plus a once-per-revolution Z index.
- Used to drive encoder inputs from the motion core for loopback test and for emulating a missing physical encoder.
- One instance per imitated axis; its clr input is driven by the receiver bus block's per-channel clear.

---
 rtl/quad_enc_imit_if.sv | 30 +++
 rtl/quad_enc_imit.sv | 242 ++++++++++++++++++++++++
 tb/tb_quad_enc_imit.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_enc_imit_if.sv
// -----------------------------------------------------------------------------
// quad_enc_imit_if
// Request/observation bundle for one quadrature encoder imitator channel.
//   master (motion core side): drives clr, ena, step, dir; observes outputs
//   slave  (imitator side)   : consumes clr, ena, step, dir; drives
//                              A, B, Z (quadrature + index), pos (signed
//                              emitted position), busy, overflow
// -----------------------------------------------------------------------------
interface quad_enc_imit_if;
    logic               clr;
    logic               ena;
    logic               step;
    logic               dir;
    logic               A;
    logic               B;
    logic               Z;
    logic signed [31:0] pos;
    logic               busy;
    logic               overflow;

    modport master (
        output clr, ena, step, dir,
        input  A, B, Z, pos, busy, overflow
    );

    modport slave (
        input  clr, ena, step, dir,
        output A, B, Z, pos, busy, overflow
    );
endinterface

// File: rtl/quad_enc_imit.sv
// -----------------------------------------------------------------------------
// quad_enc_imit
// Single-channel quadrature encoder imitator. Step/dir count requests are
// accumulated in a signed pending counter and paid out as rate-limited A/B
// quadrature edges (at most one edge every MIN_GAP clocks), together with a
// once-per-revolution Z index and the signed emitted position.
//
// Ports:
//   clk   system clock
//   aclr  asynchronous reset, active-high
//   sclr  synchronous clear (same effect as aclr)
//   bus   quad_enc_imit_if.slave:
//           clr      synchronous channel clear
//           ena      edge emission enable (requests still accumulate when 0)
//           step/dir one-cycle count request, dir=1 -> +1, dir=0 -> -1
//           A/B      registered quadrature phases (A leads B when counting up)
//           Z        registered index, high while revolution index is 0
//           pos      registered signed emitted position (wraps mod 2^32)
//           busy     registered (pending != 0)
//           overflow sticky: a request was dropped at saturation
// -----------------------------------------------------------------------------
module quad_enc_imit #(
    parameter int MIN_GAP = 4,
    parameter int ZPR     = 4000,
    parameter int PEND_W  = 8
) (
    input  logic           clk,
    input  logic           aclr,
    input  logic           sclr,
    quad_enc_imit_if.slave bus
);

    localparam int GAP_W = $clog2(MIN_GAP);
    localparam int REV_W = $clog2(ZPR);
    localparam int EXT_W = PEND_W + 1;

    localparam logic [GAP_W-1:0]  GAP_ZERO   = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(MIN_GAP - 1);
    localparam logic [REV_W-1:0]  REV_ZERO   = {REV_W{1'b0}};
    localparam logic [REV_W-1:0]  REV_ONE    = REV_W'(1);
    localparam logic [REV_W-1:0]  REV_LAST   = REV_W'(ZPR - 1);
    localparam logic [PEND_W-1:0] PEND_ZERO  = {PEND_W{1'b0}};
    localparam logic [EXT_W-1:0]  EXT_ZERO   = {EXT_W{1'b0}};
    localparam logic [EXT_W-1:0]  EXT_PLUS   = EXT_W'(1);
    localparam logic [EXT_W-1:0]  EXT_MINUS  = {EXT_W{1'b1}};
    localparam logic [31:0]       POS_ZERO   = 32'h0000_0000;
    localparam logic [31:0]       POS_ONE    = 32'h0000_0001;

    // Phase encoding equals {A,B} so the outputs come straight off the state.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_e;

    phase_e            phase_r;
    phase_e            phase_nxt_s;
    logic [PEND_W-1:0] pend_r;
    logic [PEND_W-1:0] pend_nxt_s;
    logic [GAP_W-1:0]  gap_r;
    logic [GAP_W-1:0]  gap_nxt_s;
    logic [REV_W-1:0]  rev_r;
    logic [REV_W-1:0]  rev_nxt_s;
    logic [31:0]       pos_r;
    logic [31:0]       pos_nxt_s;
    logic              z_r;
    logic              busy_r;
    logic              ovf_r;
    logic              ovf_nxt_s;

    logic              sync_clr_s;
    logic              emit_s;
    logic              emit_up_s;
    logic [EXT_W-1:0]  pend_ext_s;
    logic [EXT_W-1:0]  req_ext_s;
    logic [EXT_W-1:0]  emit_ext_s;
    logic [EXT_W-1:0]  sum_full_s;
    logic [EXT_W-1:0]  sum_keep_s;
    logic              sat_s;

    // Soft clear and per-channel clear have identical effect.
    assign sync_clr_s = sclr | bus.clr;

    // Edge qualification: emit from the registered pending value only, so a
    // request seen this cycle can be paid out at the earliest next cycle.
    always_comb begin
        emit_s    = 1'b0;
        emit_up_s = 1'b0;
        if (bus.ena && (gap_r == GAP_ZERO) && (pend_r != PEND_ZERO)) begin
            emit_s    = 1'b1;
            emit_up_s = ~pend_r[PEND_W-1];
        end else begin
            emit_s    = 1'b0;
            emit_up_s = 1'b0;
        end
    end

    // Pending accumulator: pending + req - emit, computed one bit wider so a
    // saturating result is detected by the two top bits disagreeing. On
    // saturation only the request is dropped; the emission is still paid.
    always_comb begin
        pend_ext_s = {pend_r[PEND_W-1], pend_r};
        req_ext_s  = EXT_ZERO;
        emit_ext_s = EXT_ZERO;
        if (bus.step) begin
            if (bus.dir) begin
                req_ext_s = EXT_PLUS;
            end else begin
                req_ext_s = EXT_MINUS;
            end
        end else begin
            req_ext_s = EXT_ZERO;
        end
        if (emit_s) begin
            if (emit_up_s) begin
                emit_ext_s = EXT_PLUS;
            end else begin
                emit_ext_s = EXT_MINUS;
            end
        end else begin
            emit_ext_s = EXT_ZERO;
        end
        sum_full_s = pend_ext_s + req_ext_s - emit_ext_s;
        sum_keep_s = pend_ext_s - emit_ext_s;
        sat_s      = sum_full_s[PEND_W] ^ sum_full_s[PEND_W-1];
        if (sat_s) begin
            pend_nxt_s = sum_keep_s[PEND_W-1:0];
            ovf_nxt_s  = 1'b1;
        end else begin
            pend_nxt_s = sum_full_s[PEND_W-1:0];
            ovf_nxt_s  = ovf_r;
        end
    end

    // Gap counter: reload on every edge, otherwise count down and park at 0.
    // It keeps running while ena is low so a resumed burst is not delayed.
    always_comb begin
        gap_nxt_s = gap_r;
        if (emit_s) begin
            gap_nxt_s = GAP_RELOAD;
        end else if (gap_r != GAP_ZERO) begin
            gap_nxt_s = gap_r - GAP_ONE;
        end else begin
            gap_nxt_s = GAP_ZERO;
        end
    end

    // Quadrature phase next state: one Gray step per edge, so only one of
    // A/B can toggle in any cycle, even across a direction reversal.
    always_comb begin
        phase_nxt_s = phase_r;
        if (emit_s) begin
            case (phase_r)
                PH_00:   phase_nxt_s = emit_up_s ? PH_10 : PH_01;
                PH_10:   phase_nxt_s = emit_up_s ? PH_11 : PH_00;
                PH_11:   phase_nxt_s = emit_up_s ? PH_01 : PH_10;
                PH_01:   phase_nxt_s = emit_up_s ? PH_00 : PH_11;
                default: phase_nxt_s = PH_00;
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Position and revolution index; the index wraps modulo ZPR in both
    // directions so Z marks the same mechanical angle either way.
    always_comb begin
        pos_nxt_s = pos_r;
        rev_nxt_s = rev_r;
        if (emit_s) begin
            if (emit_up_s) begin
                pos_nxt_s = pos_r + POS_ONE;
                if (rev_r == REV_LAST) begin
                    rev_nxt_s = REV_ZERO;
                end else begin
                    rev_nxt_s = rev_r + REV_ONE;
                end
            end else begin
                pos_nxt_s = pos_r - POS_ONE;
                if (rev_r == REV_ZERO) begin
                    rev_nxt_s = REV_LAST;
                end else begin
                    rev_nxt_s = rev_r - REV_ONE;
                end
            end
        end else begin
            pos_nxt_s = pos_r;
            rev_nxt_s = rev_r;
        end
    end

    // Phase state register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            phase_r <= PH_00;
        end else if (sync_clr_s) begin
            phase_r <= PH_00;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Datapath registers: accumulator, gap, index, position and flags all
    // update on the same edge as the phase so A/B/Z/pos stay coherent.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pend_r <= PEND_ZERO;
            gap_r  <= GAP_ZERO;
            rev_r  <= REV_ZERO;
            pos_r  <= POS_ZERO;
            z_r    <= 1'b1;
            busy_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (sync_clr_s) begin
            pend_r <= PEND_ZERO;
            gap_r  <= GAP_ZERO;
            rev_r  <= REV_ZERO;
            pos_r  <= POS_ZERO;
            z_r    <= 1'b1;
            busy_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            pend_r <= pend_nxt_s;
            gap_r  <= gap_nxt_s;
            rev_r  <= rev_nxt_s;
            pos_r  <= pos_nxt_s;
            z_r    <= (rev_nxt_s == REV_ZERO);
            busy_r <= (pend_nxt_s != PEND_ZERO);
            ovf_r  <= ovf_nxt_s;
        end
    end

    assign bus.A        = phase_r[1];
    assign bus.B        = phase_r[0];
    assign bus.Z        = z_r;
    assign bus.pos      = pos_r;
    assign bus.busy     = busy_r;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_quad_enc_imit.sv
// -----------------------------------------------------------------------------
// tb_quad_enc_imit
// Two imitators driven with identical stimulus: a default-parameter channel
// (ZPR=4000, PEND_W=8) and a small one (ZPR=4, PEND_W=4) that exposes index
// wrap and accumulator saturation. A position/pending model predicts every
// output each cycle; directed literal expectations pin the model down.
// -----------------------------------------------------------------------------
module tb_quad_enc_imit;

    localparam int MIN_GAP = 4;

    logic clk   = 1'b0;
    logic aclr  = 1'b1;
    logic sclr  = 1'b0;
    logic clr_t = 1'b0;
    logic ena_t = 1'b0;
    logic step_t = 1'b0;
    logic dir_t = 1'b0;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    quad_enc_imit_if if0 ();
    quad_enc_imit_if if1 ();

    assign if0.clr  = clr_t;
    assign if0.ena  = ena_t;
    assign if0.step = step_t;
    assign if0.dir  = dir_t;
    assign if1.clr  = clr_t;
    assign if1.ena  = ena_t;
    assign if1.step = step_t;
    assign if1.dir  = dir_t;

    quad_enc_imit #(.MIN_GAP(MIN_GAP), .ZPR(4000), .PEND_W(8)) u_dut0 (
        .clk  (clk),
        .aclr (aclr),
        .sclr (sclr),
        .bus  (if0.slave)
    );

    quad_enc_imit #(.MIN_GAP(MIN_GAP), .ZPR(4), .PEND_W(4)) u_dut1 (
        .clk  (clk),
        .aclr (aclr),
        .sclr (sclr),
        .bus  (if1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model: position, pending, gap, flags ----------------
    int                 m_zpr  [2] = '{4000, 4};
    int                 m_pmax [2] = '{127, 7};
    int                 m_pend [2] = '{0, 0};
    int                 m_gap  [2] = '{0, 0};
    logic signed [31:0] m_pos  [2] = '{32'sd0, 32'sd0};
    bit                 m_ovf  [2] = '{1'b0, 1'b0};
    bit                 m_busy [2] = '{1'b0, 1'b0};
    bit                 m_rst_evt = 1'b1;
    int                 m_e, m_r, m_nx;

    always @(posedge clk or posedge aclr) begin
        for (int i = 0; i < 2; i++) begin
            if (aclr || sclr || clr_t) begin
                m_pend[i] <= 0;
                m_gap[i]  <= 0;
                m_pos[i]  <= 32'sd0;
                m_ovf[i]  <= 1'b0;
                m_busy[i] <= 1'b0;
            end else begin
                m_e = 0;
                if (ena_t && m_gap[i] == 0 && m_pend[i] != 0) m_e = (m_pend[i] > 0) ? 1 : -1;
                m_r  = step_t ? (dir_t ? 1 : -1) : 0;
                m_nx = m_pend[i] + m_r - m_e;
                if (m_nx > m_pmax[i] || m_nx < -m_pmax[i] - 1) begin
                    m_nx = m_pend[i] - m_e;
                    m_ovf[i] <= 1'b1;
                end
                m_gap[i]  <= (m_e != 0) ? MIN_GAP - 1 : ((m_gap[i] > 0) ? m_gap[i] - 1 : 0);
                m_pos[i]  <= m_pos[i] + m_e;
                m_pend[i] <= m_nx;
                m_busy[i] <= (m_nx != 0);
            end
        end
        m_rst_evt <= aclr || sclr || clr_t;
    end

    // Quadrature phase as a function of position modulo 4.
    function automatic logic [1:0] exp_ab(input logic signed [31:0] p);
        logic [1:0] q;
        q = p[1:0];
        case (q)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // ---------------- compare process and edge log ----------------
    logic [1:0] prev_ab [2] = '{2'b00, 2'b00};
    int         q_cyc0[$];
    logic [1:0] q_ab0[$];
    logic       q_busy0[$];
    int         q_cyc1[$];
    int         q_zpos1[$];

    task automatic check_ch(input int i, input logic [1:0] ab, input logic z,
                            input logic [31:0] pos, input logic busy, input logic ovf);
        logic [1:0] eab;
        logic       ez;
        eab = exp_ab(m_pos[i]);
        ez  = ((m_pos[i] % m_zpr[i]) == 0);
        checks++;
        if ({ab, z, pos, busy, ovf} !== {eab, ez, m_pos[i], m_busy[i], m_ovf[i]}) begin
            errors++;
            $display("FAIL model_dut%0d cyc=%0d: got ab=%b z=%b pos=%0d busy=%b ovf=%b, expected ab=%b z=%b pos=%0d busy=%b ovf=%b",
                     i, cyc, ab, z, $signed(pos), busy, ovf, eab, ez, m_pos[i], m_busy[i], m_ovf[i]);
        end
        if (!m_rst_evt) begin
            checks++;
            if ($countones(ab ^ prev_ab[i]) > 1) begin
                errors++;
                $display("FAIL glitch_dut%0d cyc=%0d: ab went %b -> %b, expected at most one toggle",
                         i, cyc, prev_ab[i], ab);
            end
            if (ab != prev_ab[i]) begin
                if (i == 0) begin
                    q_cyc0.push_back(cyc);
                    q_ab0.push_back(ab);
                    q_busy0.push_back(busy);
                end else begin
                    q_cyc1.push_back(cyc);
                    if (z) q_zpos1.push_back(int'(pos));
                end
            end
        end
        prev_ab[i] = ab;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_ch(0, {if0.A, if0.B}, if0.Z, if0.pos, if0.busy, if0.overflow);
            check_ch(1, {if1.A, if1.B}, if1.Z, if1.pos, if1.busy, if1.overflow);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n, input logic d);
        for (int k = 0; k < n; k++) begin
            step_t = 1'b1;
            dir_t  = d;
            tick();
        end
        step_t = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((if0.busy || if1.busy) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_reached", (if0.busy || if1.busy) ? 32'd0 : 32'd1, 32'd1);
        tick();
    endtask

    task automatic clear_logs();
        q_cyc0.delete();
        q_ab0.delete();
        q_busy0.delete();
        q_cyc1.delete();
        q_zpos1.delete();
    endtask

    task automatic pulse_clr();
        clr_t = 1'b1;
        tick();
        clr_t = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    logic [1:0] t1_ab [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    logic [1:0] t2_ab [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    int t0;

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_ab",   {30'd0, if0.A, if0.B}, 32'd0);
        chk("rst_z",    {31'd0, if0.Z}, 32'd1);
        chk("rst_pos",  if0.pos, 32'd0);
        chk("rst_busy", {31'd0, if0.busy}, 32'd0);
        chk("rst_ovf",  {31'd0, if1.overflow}, 32'd0);
        aclr  = 1'b0;
        ena_t = 1'b1;
        tick();

        // Five positive counts back to back.
        clear_logs();
        chk("t1_z_start", {31'd0, if0.Z}, 32'd1);
        t0 = cyc;
        step_n(5, 1'b1);
        wait_idle(100);
        chk("t1_edges", q_cyc0.size(), 32'd5);
        if (q_cyc0.size() > 0) chk("t1_latency", q_cyc0[0] - t0, 32'd2);
        for (int k = 0; k < q_ab0.size() && k < 5; k++) chk("t1_ab_seq", {30'd0, q_ab0[k]}, {30'd0, t1_ab[k]});
        for (int k = 1; k < q_cyc0.size(); k++) chk("t1_spacing", q_cyc0[k] - q_cyc0[k-1], 32'd4);
        if (q_busy0.size() == 5) begin
            chk("t1_busy_before_last", {31'd0, q_busy0[3]}, 32'd1);
            chk("t1_busy_at_last", {31'd0, q_busy0[4]}, 32'd0);
        end
        chk("t1_pos", if0.pos, 32'd5);
        chk("t1_z_end", {31'd0, if0.Z}, 32'd0);

        // Five negative counts back to 0.
        clear_logs();
        step_n(5, 1'b0);
        wait_idle(100);
        chk("t2_edges", q_cyc0.size(), 32'd5);
        for (int k = 0; k < q_ab0.size() && k < 5; k++) chk("t2_ab_seq", {30'd0, q_ab0[k]}, {30'd0, t2_ab[k]});
        for (int k = 1; k < q_cyc0.size(); k++) chk("t2_spacing", q_cyc0[k] - q_cyc0[k-1], 32'd4);
        chk("t2_pos", if0.pos, 32'd0);
        chk("t2_z", {31'd0, if0.Z}, 32'd1);

        // Index on the ZPR=4 channel: nine counts, Z at 4 and 8 only.
        clear_logs();
        step_n(9, 1'b1);
        wait_idle(200);
        chk("t3_edges", q_cyc1.size(), 32'd9);
        chk("t3_pos", if1.pos, 32'd9);
        chk("t3_z_end", {31'd0, if1.Z}, 32'd0);
        chk("t3_z_hits", q_zpos1.size(), 32'd2);
        if (q_zpos1.size() == 2) begin
            chk("t3_z_pos0", q_zpos1[0], 32'd4);
            chk("t3_z_pos1", q_zpos1[1], 32'd8);
        end
        chk("t3_no_ovf", {31'd0, if1.overflow}, 32'd0);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("sclr_pos", if1.pos, 32'd0);
        chk("sclr_z", {31'd0, if1.Z}, 32'd1);
        step_n(1, 1'b0);
        wait_idle(50);
        chk("t3_neg_pos1", if1.pos, 32'hFFFF_FFFF);
        chk("t3_neg_z1", {31'd0, if1.Z}, 32'd0);
        chk("t3_neg_ab1", {30'd0, if1.A, if1.B}, 32'd1);
        chk("t3_neg_pos0", if0.pos, 32'hFFFF_FFFF);
        step_n(1, 1'b1);
        wait_idle(50);
        chk("t3_back_z1", {31'd0, if1.Z}, 32'd1);

        // Reversal while pending, then an ena pause mid-burst.
        step_n(3, 1'b1);
        step_n(3, 1'b0);
        wait_idle(100);
        step_n(2, 1'b1);
        ena_t = 1'b0;
        repeat (6) tick();
        ena_t = 1'b1;
        wait_idle(100);

        // Saturation with emission disabled.
        pulse_clr();
        clear_logs();
        ena_t = 1'b0;
        step_n(10, 1'b1);
        repeat (3) tick();
        chk("t4_ovf1", {31'd0, if1.overflow}, 32'd1);
        chk("t4_ovf0", {31'd0, if0.overflow}, 32'd0);
        chk("t4_busy1", {31'd0, if1.busy}, 32'd1);
        chk("t4_no_edges", q_cyc1.size(), 32'd0);
        ena_t = 1'b1;
        wait_idle(200);
        chk("t4_edges1", q_cyc1.size(), 32'd7);
        chk("t4_pos1", if1.pos, 32'd7);
        chk("t4_ovf1_sticky", {31'd0, if1.overflow}, 32'd1);
        chk("t4_edges0", q_cyc0.size(), 32'd10);
        chk("t4_pos0", if0.pos, 32'd10);

        // Mid-burst clr (pending=3) with a concurrent step.
        step_n(4, 1'b1);
        clr_t  = 1'b1;
        step_t = 1'b1;
        dir_t  = 1'b1;
        tick();
        clr_t  = 1'b0;
        step_t = 1'b0;
        chk("t5_ab",   {30'd0, if0.A, if0.B}, 32'd0);
        chk("t5_pos",  if0.pos, 32'd0);
        chk("t5_z",    {31'd0, if0.Z}, 32'd1);
        chk("t5_busy", {31'd0, if0.busy}, 32'd0);
        chk("t5_ovf1", {31'd0, if1.overflow}, 32'd0);
        clear_logs();
        repeat (20) tick();
        chk("t5_no_edges0", q_cyc0.size(), 32'd0);
        chk("t5_no_edges1", q_cyc1.size(), 32'd0);

        // Asynchronous reset between edges, step held across release.
        step_n(3, 1'b1);
        tick();
        #3;
        aclr   = 1'b1;
        step_t = 1'b1;
        #1;
        chk("t6_ab",   {30'd0, if0.A, if0.B}, 32'd0);
        chk("t6_pos",  if0.pos, 32'd0);
        chk("t6_z",    {31'd0, if0.Z}, 32'd1);
        chk("t6_busy", {31'd0, if0.busy}, 32'd0);
        chk("t6_pos1", if1.pos, 32'd0);
        tick();
        #2;
        aclr   = 1'b0;
        step_t = 1'b0;
        clear_logs();
        repeat (12) tick();
        chk("t6_no_edges", q_cyc0.size(), 32'd0);
        chk("t6_pos_hold", if0.pos, 32'd0);
        step_n(1, 1'b1);
        wait_idle(50);
        chk("t6_new_edge", q_cyc0.size(), 32'd1);
        chk("t6_new_pos", if0.pos, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
